dcache_controller: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache controller with two-word blocks.
- Sits between the pipeline MEM stage and data_memory, and is the initiator side of the memory's ReadMiss/ReadReady and MemWriteThrough/WriteReady handshakes.
- Serves read hits with zero added latency.
- Stalls the pipeline on read misses (block fill) and on every store (write-through).

---
 rtl/dcache_pkg.sv | 18 +
 rtl/dcache_array.sv | 46 ++++
 rtl/dcache_controller.sv | 139 +++++++++++++
 tb/tb_dcache_controller.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped, write-through data cache:
// default geometry, address field positions and controller state encoding.
package dcache_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_NUM_SETS = 8;
  localparam int BLOCK_OFF = 3;
  localparam int OFFSET_BIT = 2;
  localparam int INDEX_BITS = $clog2(DEF_NUM_SETS);
  localparam int TAG_W = DEF_ADDR_W - BLOCK_OFF - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_e;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous write
// port that either fills a whole two-word line or updates a single word.
module dcache_array #(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = 3,
  parameter int TAG_BITS = 26
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IDX_W-1:0]    rd_index_i,
  output logic                rd_valid_o,
  output logic [TAG_BITS-1:0] rd_tag_o,
  output logic [63:0]         rd_line_o,
  input  logic                fill_en_i,
  input  logic [IDX_W-1:0]    fill_index_i,
  input  logic [TAG_BITS-1:0] fill_tag_i,
  input  logic [63:0]         fill_data_i,
  input  logic                upd_en_i,
  input  logic [IDX_W-1:0]    upd_index_i,
  input  logic                upd_offset_i,
  input  logic [31:0]         upd_word_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_BITS-1:0] tag_q  [NUM_SETS];
  logic [63:0]         data_q [NUM_SETS];

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_line_o  = data_q[rd_index_i];

  // Only the valid bits are cleared; stale tags/data are harmless once invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_index_i] <= 1'b1;
      tag_q[fill_index_i]   <= fill_tag_i;
      data_q[fill_index_i]  <= fill_data_i;
    end else if (upd_en_i) begin
      if (upd_offset_i) data_q[upd_index_i][63:32] <= upd_word_i;
      else              data_q[upd_index_i][31:0]  <= upd_word_i;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with
// two-word blocks; read hits return in the same cycle, misses and stores stall.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       Write_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [31:0]       Read_data,
  output logic              Stall,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [63:0]       MemWrite_data,
  output logic              ReadMiss,
  output logic              MemWriteThrough,
  input  logic [63:0]       Mem_read_data,
  input  logic              ReadReady,
  input  logic              WriteReady,
  output state_e            dbg_state_o
);

  localparam int IDX_W    = $clog2(NUM_SETS);
  localparam int TAG_BITS = ADDR_W - BLOCK_OFF - IDX_W;

  state_e              state_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic                read_miss_q;
  logic                write_thru_q;
  logic                wr_hit_q;

  logic [IDX_W-1:0]    index;
  logic [TAG_BITS-1:0] tag;
  logic                offset;
  logic                line_valid;
  logic [TAG_BITS-1:0] line_tag;
  logic [63:0]         line_data;
  logic                hit;
  logic [31:0]         hit_word;
  logic                fill_en;
  logic                upd_en;
  logic                unused_addr_bits;

  assign index            = Address[BLOCK_OFF +: IDX_W];
  assign tag              = Address[ADDR_W-1 -: TAG_BITS];
  assign offset           = Address[OFFSET_BIT];
  assign unused_addr_bits = ^Address[1:0];

  assign hit      = line_valid && (line_tag == tag);
  assign hit_word = offset ? line_data[63:32] : line_data[31:0];

  // Fill and word update both address the line via the latched memory address.
  assign fill_en = (state_q == RD_MISS) && ReadReady;
  assign upd_en  = (state_q == WR_THRU) && WriteReady && wr_hit_q;

  dcache_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_BITS (TAG_BITS)
  ) u_array (
    .clk_i        (Clk),
    .rst_i        (Rst),
    .rd_index_i   (index),
    .rd_valid_o   (line_valid),
    .rd_tag_o     (line_tag),
    .rd_line_o    (line_data),
    .fill_en_i    (fill_en),
    .fill_index_i (mem_addr_q[BLOCK_OFF +: IDX_W]),
    .fill_tag_i   (mem_addr_q[ADDR_W-1 -: TAG_BITS]),
    .fill_data_i  (Mem_read_data),
    .upd_en_i     (upd_en),
    .upd_index_i  (mem_addr_q[BLOCK_OFF +: IDX_W]),
    .upd_offset_i (mem_addr_q[OFFSET_BIT]),
    .upd_word_i   (mem_wdata_q)
  );

  // Handshake: a request stays high until an edge samples its ready; a ready
  // seen while the matching request is low is ignored.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      read_miss_q  <= 1'b0;
      write_thru_q <= 1'b0;
      wr_hit_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MemWrite) begin
            mem_addr_q   <= {Address[ADDR_W-1:OFFSET_BIT], {OFFSET_BIT{1'b0}}};
            mem_wdata_q  <= Write_data;
            wr_hit_q     <= hit;
            write_thru_q <= 1'b1;
            state_q      <= WR_THRU;
          end else if (MemRead && !hit) begin
            mem_addr_q  <= {Address[ADDR_W-1:BLOCK_OFF], {BLOCK_OFF{1'b0}}};
            read_miss_q <= 1'b1;
            state_q     <= RD_MISS;
          end
        end
        RD_MISS: begin
          if (ReadReady) begin
            read_miss_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        WR_THRU: begin
          if (WriteReady) begin
            write_thru_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    Stall     = 1'b1;
    Read_data = '0;
    if (state_q == IDLE) begin
      Stall = MemWrite || (MemRead && !hit);
      if (MemRead && !MemWrite && hit) Read_data = hit_word;
    end
  end

  assign MemAddress      = mem_addr_q;
  assign MemWrite_data   = {32'b0, mem_wdata_q};
  assign ReadMiss        = read_miss_q;
  assign MemWriteThrough = write_thru_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: the bench plays both the pipeline and
// a word-addressed data memory and checks handshakes and returned data.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] Write_data = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Read_data;
  logic        Stall;
  logic [31:0] MemAddress;
  logic [63:0] MemWrite_data;
  logic        ReadMiss;
  logic        MemWriteThrough;
  logic [63:0] Mem_read_data = '0;
  logic        ReadReady = 1'b0;
  logic        WriteReady = 1'b0;
  state_e      dbg_state;

  int chk_n = 0;
  int fail_n = 0;
  logic [31:0] mem_words [0:127];

  dcache_controller dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Address         (Address),
    .Write_data      (Write_data),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .Read_data       (Read_data),
    .Stall           (Stall),
    .MemAddress      (MemAddress),
    .MemWrite_data   (MemWrite_data),
    .ReadMiss        (ReadMiss),
    .MemWriteThrough (MemWriteThrough),
    .Mem_read_data   (Mem_read_data),
    .ReadReady       (ReadReady),
    .WriteReady      (WriteReady),
    .dbg_state_o     (dbg_state)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(negedge Clk);
  endtask

  // Load (hit or miss) with the bench memory as the responder.
  task automatic do_read(input logic [31:0] addr, input logic exp_miss, input int lat, input string nm);
    logic [31:0] blk;
    logic [31:0] exp_data;
    blk = {addr[31:3], 3'b000};
    exp_data = mem_words[addr >> 2];
    Address = addr; MemRead = 1'b1;
    #1;
    if (exp_miss) begin
      chk_n++; if (Stall !== 1'b1) begin fail_n++; $display("FAIL %s miss_stall: got %b want 1", nm, Stall); end
      tick();
      chk_n++; if (ReadMiss !== 1'b1) begin fail_n++; $display("FAIL %s readmiss_rise: got %b want 1", nm, ReadMiss); end
      chk_n++; if (MemAddress !== blk) begin fail_n++; $display("FAIL %s miss_addr: got %h want %h", nm, MemAddress, blk); end
      chk_n++; if (MemWriteThrough !== 1'b0) begin fail_n++; $display("FAIL %s wt_during_miss: got %b want 0", nm, MemWriteThrough); end
      for (int i = 0; i < lat; i++) begin
        tick();
        chk_n++; if (ReadMiss !== 1'b1 || Stall !== 1'b1) begin fail_n++; $display("FAIL %s miss_hold: got rm=%b st=%b want 1/1", nm, ReadMiss, Stall); end
        chk_n++; if (MemAddress !== blk) begin fail_n++; $display("FAIL %s miss_addr_stable: got %h want %h", nm, MemAddress, blk); end
      end
      Mem_read_data = {mem_words[(blk >> 2) + 1], mem_words[blk >> 2]};
      ReadReady = 1'b1;
      tick();
      ReadReady = 1'b0; Mem_read_data = '0;
      #1;
      chk_n++; if (ReadMiss !== 1'b0) begin fail_n++; $display("FAIL %s readmiss_fall: got %b want 0", nm, ReadMiss); end
    end
    chk_n++; if (Stall !== 1'b0) begin fail_n++; $display("FAIL %s hit_stall: got %b want 0", nm, Stall); end
    chk_n++; if (Read_data !== exp_data) begin fail_n++; $display("FAIL %s read_data: got %h want %h", nm, Read_data, exp_data); end
    tick();
    chk_n++; if (ReadMiss !== 1'b0) begin fail_n++; $display("FAIL %s no_refetch: got %b want 0", nm, ReadMiss); end
    MemRead = 1'b0;
  endtask

  // Store through to memory; the bench memory is updated at completion.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int lat, input string nm);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    Address = addr; Write_data = data; MemWrite = 1'b1;
    #1;
    chk_n++; if (Stall !== 1'b1) begin fail_n++; $display("FAIL %s wr_stall: got %b want 1", nm, Stall); end
    tick();
    for (int i = 0; i <= lat; i++) begin
      if (i > 0) tick();
      chk_n++; if (MemWriteThrough !== 1'b1 || ReadMiss !== 1'b0) begin fail_n++; $display("FAIL %s wt_hold: got wt=%b rm=%b want 1/0", nm, MemWriteThrough, ReadMiss); end
      chk_n++; if (MemAddress !== waddr) begin fail_n++; $display("FAIL %s wt_addr: got %h want %h", nm, MemAddress, waddr); end
      chk_n++; if (MemWrite_data !== {32'b0, data}) begin fail_n++; $display("FAIL %s wt_data: got %h want %h", nm, MemWrite_data, {32'b0, data}); end
    end
    WriteReady = 1'b1;
    tick();
    WriteReady = 1'b0; MemWrite = 1'b0;
    mem_words[waddr >> 2] = data;
    #1;
    chk_n++; if (MemWriteThrough !== 1'b0 || Stall !== 1'b0) begin fail_n++; $display("FAIL %s wt_done: got wt=%b st=%b want 0/0", nm, MemWriteThrough, Stall); end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick(); tick();
    Rst = 1'b0;
    #1;
    chk_n++; if (Stall !== 1'b0 || Read_data !== 32'h0) begin fail_n++; $display("FAIL reset_out: got st=%b rd=%h want 0/0", Stall, Read_data); end
    chk_n++; if (ReadMiss !== 1'b0 || MemWriteThrough !== 1'b0) begin fail_n++; $display("FAIL reset_req: got rm=%b wt=%b want 0/0", ReadMiss, MemWriteThrough); end
    chk_n++; if (MemAddress !== 32'h0 || MemWrite_data !== 64'h0) begin fail_n++; $display("FAIL reset_bus: got %h/%h want 0/0", MemAddress, MemWrite_data); end
    chk_n++; if (dbg_state !== IDLE) begin fail_n++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_rw_priority();
    Address = 32'h40; Write_data = 32'h77; MemRead = 1'b1; MemWrite = 1'b1;
    #1;
    chk_n++; if (Stall !== 1'b1) begin fail_n++; $display("FAIL prio_stall: got %b want 1", Stall); end
    tick();
    chk_n++; if (MemWriteThrough !== 1'b1 || ReadMiss !== 1'b0) begin fail_n++; $display("FAIL prio_req: got wt=%b rm=%b want 1/0", MemWriteThrough, ReadMiss); end
    WriteReady = 1'b1;
    tick();
    WriteReady = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
    mem_words[32'h40 >> 2] = 32'h77;
    do_read(32'h40, 1'b0, 0, "prio_readback");
  endtask

  task automatic test_stray_ready();
    Address = 32'h40;
    Mem_read_data = 64'hFFFF_FFFF_FFFF_FFFF; ReadReady = 1'b1; WriteReady = 1'b1;
    tick();
    ReadReady = 1'b0; WriteReady = 1'b0; Mem_read_data = '0;
    #1;
    chk_n++; if (ReadMiss !== 1'b0 || MemWriteThrough !== 1'b0 || dbg_state !== IDLE) begin fail_n++; $display("FAIL stray_ready: got rm=%b wt=%b state=%0d want 0/0/0", ReadMiss, MemWriteThrough, dbg_state); end
    do_read(32'h40, 1'b0, 0, "stray_readback");
  endtask

  task automatic test_reset_mid_miss();
    Address = 32'h100; MemRead = 1'b1;
    tick();
    chk_n++; if (ReadMiss !== 1'b1) begin fail_n++; $display("FAIL rstmid_req: got %b want 1", ReadMiss); end
    Rst = 1'b1; MemRead = 1'b0;
    tick();
    Rst = 1'b0;
    #1;
    chk_n++; if (ReadMiss !== 1'b0 || Stall !== 1'b0 || MemAddress !== 32'h0) begin fail_n++; $display("FAIL rstmid_drop: got rm=%b st=%b ma=%h want 0/0/0", ReadMiss, Stall, MemAddress); end
    Mem_read_data = 64'hBAD0_BAD0_BAD0_BAD0; ReadReady = 1'b1;
    tick();
    ReadReady = 1'b0; Mem_read_data = '0;
    #1;
    chk_n++; if (ReadMiss !== 1'b0 || dbg_state !== IDLE) begin fail_n++; $display("FAIL rstmid_late_ready: got rm=%b state=%0d want 0/0", ReadMiss, dbg_state); end
    do_read(32'h100, 1'b1, 1, "rstmid_reread");
    do_read(32'h48, 1'b1, 0, "rstmid_cleared_set1");
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem_words[i] = 32'hA000_0000 | i;
    mem_words[32'h40 >> 2] = 32'h1111_1111;
    mem_words[32'h44 >> 2] = 32'h2222_2222;

    test_reset();
    do_read(32'h44, 1'b1, 3, "cold_miss");
    do_read(32'h40, 1'b0, 0, "spatial_hit");
    do_write(32'h44, 32'hDEAD_BEEF, 2, "write_hit");
    do_read(32'h44, 1'b0, 0, "write_hit_read");
    do_write(32'h80, 32'h0000_0005, 1, "write_miss");
    do_read(32'h80, 1'b1, 2, "write_miss_noalloc");
    do_read(32'h40, 1'b1, 1, "conflict_a");
    do_read(32'h80, 1'b1, 0, "conflict_b");
    do_read(32'h40, 1'b1, 1, "conflict_a_again");
    do_read(32'h48, 1'b1, 0, "set1_miss");
    do_read(32'h4C, 1'b0, 0, "set1_hit");
    do_read(32'h44, 1'b0, 0, "set0_kept");
    test_rw_priority();
    test_stray_ready();
    test_reset_mid_miss();

    $display("End of test - %0d assertions evaluated, %0d failures", chk_n, fail_n);
    $finish;
  end

endmodule
